// File: rtl/vga_frame_checker_if.sv
// Tap bundle between a VGA pixel pipeline and the frame checker.
// master drives sync/colour and reads results; slave is the checker side.
interface vga_frame_checker_if #(
    parameter int COLOR_W = 4
);
    logic               en;
    logic               hs;
    logic               vs;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               frame_valid;
    logic [31:0]        frame_crc;
    logic [15:0]        frame_lines;
    logic [15:0]        line_pixels;
    logic [15:0]        frame_count;
    logic               h_err;
    logic               v_err;
    logic               sync_lost;

    modport master (
        output en, hs, vs, r, g, b,
        input  frame_valid, frame_crc, frame_lines, line_pixels,
               frame_count, h_err, v_err, sync_lost
    );

    modport slave (
        input  en, hs, vs, r, g, b,
        output frame_valid, frame_crc, frame_lines, line_pixels,
               frame_count, h_err, v_err, sync_lost
    );
endinterface

// File: rtl/vga_frame_checker.sv
// Passive VGA frame monitor: line/frame timing check plus per-frame CRC-32 of {r,g,b}.
// Results appear 1 clk after the vs edge; purely observing, never backpressures.
module vga_frame_checker #(
    parameter int   COLOR_W   = 4,
    parameter int   H_TOTAL   = 1056,
    parameter int   V_TOTAL   = 628,
    parameter logic HS_ACTIVE = 1'b1,
    parameter logic VS_ACTIVE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_frame_checker_if.slave  mon
);
    localparam int          PIX_W    = 3 * COLOR_W;
    localparam logic [31:0] POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [15:0] H_TOT16  = 16'(H_TOTAL);
    localparam logic [15:0] V_TOT16  = 16'(V_TOTAL);
    localparam logic [15:0] WD_LIMIT = 16'(2 * H_TOTAL);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [31:0] r_crc;
    logic [15:0] r_pix_cnt;
    logic [15:0] r_line_cnt;
    logic        r_h_err_acc;
    logic        r_frame_valid;
    logic [31:0] r_frame_crc;
    logic [15:0] r_frame_lines;
    logic [15:0] r_line_pixels;
    logic [15:0] r_frame_count;
    logic        r_h_err;
    logic        r_v_err;
    logic        r_sync_lost;

    logic             w_hs_edge;
    logic             w_vs_edge;
    logic [PIX_W-1:0] w_pix;
    logic [15:0]      w_period;
    logic             w_line_bad;

    // One word per pixel clock, MSB of r first, unrolled into a single-cycle update.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [PIX_W-1:0] d);
        logic [31:0] x;
        x = c;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            x = {x[30:0], 1'b0} ^ ((x[31] ^ d[i]) ? POLY : 32'h0);
        end
        return x;
    endfunction

    assign w_hs_edge  = (mon.hs == HS_ACTIVE) && (r_hs_prev != HS_ACTIVE);
    assign w_vs_edge  = (mon.vs == VS_ACTIVE) && (r_vs_prev != VS_ACTIVE);
    assign w_pix      = {mon.r, mon.g, mon.b};
    assign w_period   = r_pix_cnt + 16'd1;
    assign w_line_bad = w_hs_edge && (w_period != H_TOT16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_hs_prev     <= ~HS_ACTIVE;
            r_vs_prev     <= ~VS_ACTIVE;
            r_crc         <= CRC_INIT;
            r_pix_cnt     <= 16'd0;
            r_line_cnt    <= 16'd0;
            r_h_err_acc   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_crc   <= 32'd0;
            r_frame_lines <= 16'd0;
            r_line_pixels <= 16'd0;
            r_frame_count <= 16'd0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_sync_lost   <= 1'b0;
        end else begin
            r_hs_prev     <= mon.hs;
            r_vs_prev     <= mon.vs;
            r_frame_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mon.en && w_vs_edge) begin
                        r_state     <= RUN;
                        r_crc       <= crc_next(CRC_INIT, w_pix);
                        r_pix_cnt   <= 16'd0;
                        r_line_cnt  <= w_hs_edge ? 16'd1 : 16'd0;
                        r_h_err_acc <= 1'b0;
                    end
                end
                RUN: begin
                    if (!mon.en) begin
                        r_state <= IDLE;
                    end else if (r_pix_cnt >= WD_LIMIT) begin
                        r_state     <= IDLE;
                        r_sync_lost <= 1'b1;
                    end else begin
                        if (w_hs_edge) begin
                            r_pix_cnt     <= 16'd0;
                            r_line_pixels <= w_period;
                        end else if (r_pix_cnt != 16'hFFFF) begin
                            r_pix_cnt <= r_pix_cnt + 16'd1;
                        end
                        // A coincident hs edge opens the new frame but its period closes the old one.
                        if (w_vs_edge) begin
                            r_frame_valid <= 1'b1;
                            r_frame_crc   <= r_crc ^ CRC_INIT;
                            r_frame_lines <= r_line_cnt;
                            r_v_err       <= (r_line_cnt != V_TOT16);
                            r_h_err       <= r_h_err_acc | w_line_bad;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_crc         <= crc_next(CRC_INIT, w_pix);
                            r_h_err_acc   <= 1'b0;
                            r_line_cnt    <= w_hs_edge ? 16'd1 : 16'd0;
                        end else begin
                            r_crc       <= crc_next(r_crc, w_pix);
                            r_h_err_acc <= r_h_err_acc | w_line_bad;
                            if (w_hs_edge && (r_line_cnt != 16'hFFFF)) begin
                                r_line_cnt <= r_line_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mon.frame_valid = r_frame_valid;
    assign mon.frame_crc   = r_frame_crc;
    assign mon.frame_lines = r_frame_lines;
    assign mon.line_pixels = r_line_pixels;
    assign mon.frame_count = r_frame_count;
    assign mon.h_err       = r_h_err;
    assign mon.v_err       = r_v_err;
    assign mon.sync_lost   = r_sync_lost;
endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker: two instances (positive 4-bit and negative 8-bit polarity)
// driven with directed frame shapes and random colour, compared to an event-time reference model.
module tb_vga_frame_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_checker_if #(.COLOR_W(4)) if_a ();
    vga_frame_checker_if #(.COLOR_W(8)) if_b ();

    vga_frame_checker #(.COLOR_W(4), .H_TOTAL(40), .V_TOTAL(12),
                        .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1))
        u_a (.clk(clk), .rst_n(rst_n), .mon(if_a.slave));

    vga_frame_checker #(.COLOR_W(8), .H_TOTAL(24), .V_TOTAL(10),
                        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0))
        u_b (.clk(clk), .rst_n(rst_n), .mon(if_b.slave));

    int checks = 0;
    int errors = 0;
    int cur = 0;
    int mH = 40, mV = 12, mW = 12;

    // reference model state (levels are logical: 1 = asserted)
    bit          m_armed, m_hsp, m_vsp, m_herr;
    int          m_t, m_tref, m_lines;
    logic [31:0] m_crc;
    bit          e_fv, e_herr, e_verr, e_sl;
    logic [31:0] e_crc;
    int          e_lines, e_lp;
    logic [15:0] e_fc;

    logic        o_fv, o_herr, o_verr, o_sl;
    logic [31:0] o_crc;
    logic [15:0] o_lines, o_lp, o_fc;

    logic [31:0] q_crc[$];
    logic [15:0] q_lines[$], q_lp[$], q_fc[$];
    logic        q_herr[$], q_verr[$];

    always_comb begin
        if (cur == 0) begin
            o_fv = if_a.frame_valid; o_crc = if_a.frame_crc; o_lines = if_a.frame_lines;
            o_lp = if_a.line_pixels; o_fc = if_a.frame_count; o_herr = if_a.h_err;
            o_verr = if_a.v_err; o_sl = if_a.sync_lost;
        end else begin
            o_fv = if_b.frame_valid; o_crc = if_b.frame_crc; o_lines = if_b.frame_lines;
            o_lp = if_b.line_pixels; o_fc = if_b.frame_count; o_herr = if_b.h_err;
            o_verr = if_b.v_err; o_sl = if_b.sync_lost;
        end
    end

    // CRC-32 as polynomial division: align the word under the register top, then divide w bits.
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [23:0] d, input int w);
        logic [31:0] x;
        x = c ^ ({8'h00, d} << (32 - w));
        for (int k = 0; k < w; k++) x = x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string t);
        chk({t, ".frame_valid"}, 32'(o_fv), 32'(e_fv));
        chk({t, ".frame_crc"}, o_crc, e_crc);
        chk({t, ".frame_lines"}, 32'(o_lines), 32'(e_lines));
        chk({t, ".line_pixels"}, 32'(o_lp), 32'(e_lp));
        chk({t, ".frame_count"}, 32'(o_fc), 32'(e_fc));
        chk({t, ".h_err"}, 32'(o_herr), 32'(e_herr));
        chk({t, ".v_err"}, 32'(o_verr), 32'(e_verr));
        chk({t, ".sync_lost"}, 32'(o_sl), 32'(e_sl));
    endtask

    task automatic model_reset();
        m_armed = 0; m_hsp = 0; m_vsp = 0; m_herr = 0;
        m_t = 0; m_tref = 0; m_lines = 0; m_crc = 32'hFFFFFFFF;
        e_fv = 0; e_herr = 0; e_verr = 0; e_sl = 0; e_crc = 0;
        e_lines = 0; e_lp = 0; e_fc = 0;
    endtask

    task automatic model_step(input bit en, input bit hs, input bit vs, input logic [23:0] px);
        bit hs_e, vs_e, bad;
        int per;
        hs_e = hs && !m_hsp;
        vs_e = vs && !m_vsp;
        m_hsp = hs; m_vsp = vs; e_fv = 0;
        if (!m_armed) begin
            if (en && vs_e) begin
                m_armed = 1; m_tref = m_t; m_lines = hs_e ? 1 : 0; m_herr = 0;
                m_crc = crc_ref(32'hFFFFFFFF, px, mW);
            end
        end else if (!en) begin
            m_armed = 0;
        end else if (m_t - m_tref > 2 * mH) begin
            m_armed = 0; e_sl = 1;
        end else begin
            per = m_t - m_tref;
            bad = hs_e && (per != mH);
            if (hs_e) begin e_lp = per; m_tref = m_t; end
            if (vs_e) begin
                e_fv = 1; e_crc = ~m_crc; e_lines = m_lines; e_verr = (m_lines != mV);
                e_herr = m_herr || bad; e_fc = e_fc + 16'd1;
                m_crc = crc_ref(32'hFFFFFFFF, px, mW); m_lines = hs_e ? 1 : 0; m_herr = 0;
            end else begin
                m_crc = crc_ref(m_crc, px, mW);
                m_lines = m_lines + (hs_e ? 1 : 0);
                m_herr = m_herr || bad;
            end
        end
        m_t++;
    endtask

    task automatic step(input bit en, input bit hs, input bit vs, input logic [23:0] pix);
        logic [23:0] pm;
        @(negedge clk);
        if (cur == 0) begin
            if_a.en = en; if_a.hs = hs; if_a.vs = vs;
            if_a.r = pix[11:8]; if_a.g = pix[7:4]; if_a.b = pix[3:0];
            pm = {12'h000, pix[11:0]};
        end else begin
            if_b.en = en; if_b.hs = ~hs; if_b.vs = ~vs;
            if_b.r = pix[23:16]; if_b.g = pix[15:8]; if_b.b = pix[7:0];
            pm = pix;
        end
        @(posedge clk);
        #1;
        model_step(en, hs, vs, pm);
        chk_all("cyc");
        if (o_fv) begin
            q_crc.push_back(o_crc); q_lines.push_back(o_lines); q_lp.push_back(o_lp);
            q_fc.push_back(o_fc); q_herr.push_back(o_herr); q_verr.push_back(o_verr);
        end
    endtask

    // Sync pulse in the first 4 clocks of each line; vs asserted for 2 lines from vs_off.
    task automatic gen_frame(input int nlines, input int short_idx, input int short_len,
                             input int vs_off, input int drop_at, input bit rnd);
        int pos, len;
        bit hs, vs, en;
        logic [23:0] px;
        pos = 0;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == short_idx) ? short_len : mH;
            for (int p = 0; p < len; p++) begin
                hs = (p < 4);
                vs = (pos >= vs_off) && (pos < vs_off + 2 * mH);
                en = !((drop_at >= 0) && (pos >= drop_at) && (pos < drop_at + 10));
                px = rnd ? 24'($urandom) : 24'hAAAAAA;
                step(en, hs, vs, px);
                pos++;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          sz;
    logic [31:0] gold;

    initial begin
        if_a.en = 0; if_a.hs = 0; if_a.vs = 0; if_a.r = 0; if_a.g = 0; if_a.b = 0;
        if_b.en = 0; if_b.hs = 1; if_b.vs = 1; if_b.r = 0; if_b.g = 0; if_b.b = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;

        // nominal constant-colour frames: first vs edge only arms
        repeat (3) gen_frame(12, -1, 0, 0, -1, 0);
        chk("nom.count", q_fc.size(), 2);
        gold = 32'hFFFFFFFF;
        for (int i = 0; i < 40 * 12; i++) gold = crc_ref(gold, 24'hAAA, 12);
        chk("nom.crc_gold", q_crc[0], ~gold);
        chk("nom.crc_same", q_crc[1], q_crc[0]);
        chk("nom.fc1", 32'(q_fc[0]), 1);
        chk("nom.fc2", 32'(q_fc[1]), 2);
        chk("nom.lines", 32'(q_lines[1]), 12);
        chk("nom.lp", 32'(q_lp[1]), 40);
        chk("nom.herr", 32'(q_herr[1]), 0);
        chk("nom.verr", 32'(q_verr[1]), 0);

        // shortened line 5 (34 clocks)
        gen_frame(12, 5, 34, 0, -1, 0);
        gen_frame(12, -1, 0, 0, -1, 0);
        chk("short.herr", 32'(q_herr[$]), 1);
        chk("short.verr", 32'(q_verr[$]), 0);
        chk("short.crc_differs", 32'(q_crc[$] != q_crc[1]), 1);
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("after_short.herr", 32'(q_herr[$]), 0);

        // 11-line frame
        gen_frame(11, -1, 0, 0, -1, 1);
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("short_frame.verr", 32'(q_verr[$]), 1);
        chk("short_frame.lines", 32'(q_lines[$]), 11);

        // vs edge mid-line, steady state
        gen_frame(12, -1, 0, 20, -1, 1);
        gen_frame(12, -1, 0, 20, -1, 1);
        chk("midline.lines", 32'(q_lines[$]), 12);
        chk("midline.verr", 32'(q_verr[$]), 0);
        chk("midline.herr", 32'(q_herr[$]), 0);
        gen_frame(12, -1, 0, 0, -1, 1);
        gen_frame(12, -1, 0, 0, -1, 1);

        // hs stuck inactive past the watchdog, then re-arm
        repeat (2 * 40 + 5) step(1, 0, 0, 24'h000123);
        chk("wd.sync_lost", 32'(o_sl), 1);
        sz = q_fc.size();
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("wd.no_fv_on_rearm", q_fc.size(), sz);
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("wd.fv_after_rearm", q_fc.size(), sz + 1);

        // en dropped mid-frame
        gen_frame(12, -1, 0, 0, 200, 1);
        sz = q_fc.size();
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("en_drop.no_fv", q_fc.size(), sz);
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("en_drop.fv", q_fc.size(), sz + 1);

        // async reset mid-frame
        gen_frame(5, -1, 0, 0, -1, 1);
        pulse_reset();
        chk("rst.frame_count", 32'(o_fc), 0);
        chk("rst.sync_lost", 32'(o_sl), 0);
        gen_frame(12, -1, 0, 0, -1, 1);
        gen_frame(12, -1, 0, 0, -1, 1);
        chk("rst.fc_restart", 32'(q_fc[$]), 1);

        // negative polarity, 24-bit colour instance
        @(negedge clk);
        if_a.en = 0;
        cur = 1; mH = 24; mV = 10; mW = 24;
        pulse_reset();
        sz = q_fc.size();
        repeat (4) gen_frame(10, -1, 0, 0, -1, 1);
        chk("neg.count", q_fc.size(), sz + 3);
        chk("neg.lines", 32'(q_lines[$]), 10);
        chk("neg.lp", 32'(q_lp[$]), 24);
        chk("neg.herr", 32'(q_herr[$]), 0);
        chk("neg.verr", 32'(q_verr[$]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
